// File: rtl/cpu16_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu16_pkg
//  Purpose  : Shared encodings for the 16-bit multicycle CPU control path:
//             opcodes, ALU operations, PC source selects and FSM states.
//  Revision : 1.0  initial release
// ============================================================================
package cpu16_pkg;

    // Instruction opcodes, IR[15:12]
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_LW    = 4'b0010;
    localparam logic [3:0] OP_SW    = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_J     = 4'b0101;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    // ALU operation selects
    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_SLT  = 3'd4;

    // PC source selects
    localparam int         PC_SRC_W      = 2;
    localparam logic [1:0] PC_SRC_INC    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    // Control FSM states
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl_if
//  Purpose  : Bundle between the control FSM (master) and the datapath /
//             memory side (slave): IR fields, flags, handshake and controls.
//  Revision : 1.0  initial release
// ============================================================================
interface multicycle_ctrl_if
    import cpu16_pkg::*;
#(
    parameter int OPC_W   = 4,
    parameter int ALUOP_W = 3
);
    logic [OPC_W-1:0]    opcode;
    logic [2:0]          funct;
    logic                zero;
    logic                mem_ready;
    logic                mem_req;
    logic                mem_we;
    logic                iord;
    logic                ir_we;
    logic                pc_we;
    logic [PC_SRC_W-1:0] pc_src;
    logic                alu_src_b;
    logic [ALUOP_W-1:0]  alu_op;
    logic                reg_we;
    logic                wb_sel;
    logic                halted;
    logic                fault;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_req, mem_we, iord, ir_we, pc_we, pc_src,
               alu_src_b, alu_op, reg_we, wb_sel, halted, fault
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_we, pc_we, pc_src,
               alu_src_b, alu_op, reg_we, wb_sel, halted, fault
    );
endinterface
`default_nettype wire

// File: rtl/mem_watchdog.sv
`default_nettype none
// ============================================================================
//  Module   : mem_watchdog
//  Purpose  : Counts wait cycles of an outstanding memory access and flags
//             expiry when the limit is reached with the memory still not ready.
//  Revision : 1.0  initial release
// ============================================================================
module mem_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clear,
    input  wire logic busy,
    input  wire logic ready,
    output logic      expire
);
    logic [7:0] r_count;

    // Wait-cycle counter: cleared between accesses, advances on each unanswered request cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (busy && !ready) begin
            r_count <= r_count + 8'd1;
        end
    end

    // A ready arriving on the limit cycle still wins
    assign expire = busy && !ready && (r_count == 8'(TIMEOUT));

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl
//  Purpose  : Multicycle control FSM for the 16-bit CPU: fetch, decode,
//             execute, memory and write-back sequencing with a memory
//             req/ready handshake and a timeout watchdog.
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int OPC_W   = 4,
    parameter int ALUOP_W = 3,
    parameter int TIMEOUT = 15
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    multicycle_ctrl_if.master  bus
);
    import cpu16_pkg::*;

    state_t r_state;
    state_t w_next;
    logic   w_busy;
    logic   w_wd_clear;
    logic   w_expire;
    logic   w_is_lw;
    logic   w_is_sw;

    assign w_is_lw    = (bus.opcode == OPC_W'(OP_LW));
    assign w_is_sw    = (bus.opcode == OPC_W'(OP_SW));
    // Only FETCH and MEM hold a memory request; reset removes it immediately
    assign w_busy     = rst_n && ((r_state == ST_FETCH) || (r_state == ST_MEM));
    // Clearing on completion makes a back-to-back access (MEM -> FETCH) start from zero
    assign w_wd_clear = !w_busy || bus.mem_ready;

    mem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_wd_clear),
        .busy   (w_busy),
        .ready  (bus.mem_ready),
        .expire (w_expire)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and control decode; everything forced low while reset is asserted
    always_comb begin
        w_next        = r_state;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.iord      = 1'b0;
        bus.ir_we     = 1'b0;
        bus.pc_we     = 1'b0;
        bus.pc_src    = PC_SRC_INC;
        bus.alu_src_b = 1'b0;
        bus.alu_op    = ALUOP_W'(ALU_ADD);
        bus.reg_we    = 1'b0;
        bus.wb_sel    = 1'b0;
        bus.halted    = 1'b0;
        bus.fault     = 1'b0;
        if (rst_n) begin
            case (r_state)
                ST_FETCH: begin
                    bus.mem_req = 1'b1;
                    if (bus.mem_ready) begin
                        bus.ir_we  = 1'b1;
                        bus.pc_we  = 1'b1;
                        bus.pc_src = PC_SRC_INC;
                        w_next     = ST_DECODE;
                    end else if (w_expire) begin
                        w_next = ST_ERR;
                    end
                end
                ST_DECODE: begin
                    case (bus.opcode)
                        OPC_W'(OP_RTYPE), OPC_W'(OP_ADDI), OPC_W'(OP_LW),
                        OPC_W'(OP_SW), OPC_W'(OP_BEQ): w_next = ST_EXEC;
                        OPC_W'(OP_J): begin
                            bus.pc_we  = 1'b1;
                            bus.pc_src = PC_SRC_JUMP;
                            w_next     = ST_FETCH;
                        end
                        OPC_W'(OP_HALT): w_next = ST_HALT;
                        default:         w_next = ST_ERR;
                    endcase
                end
                ST_EXEC: begin
                    case (bus.opcode)
                        OPC_W'(OP_RTYPE): begin
                            bus.alu_op = ALUOP_W'(bus.funct);
                            w_next     = ST_WB;
                        end
                        OPC_W'(OP_ADDI): begin
                            bus.alu_src_b = 1'b1;
                            w_next        = ST_WB;
                        end
                        OPC_W'(OP_LW), OPC_W'(OP_SW): begin
                            bus.alu_src_b = 1'b1;
                            w_next        = ST_MEM;
                        end
                        OPC_W'(OP_BEQ): begin
                            bus.alu_op = ALUOP_W'(ALU_SUB);
                            bus.pc_we  = bus.zero;
                            bus.pc_src = PC_SRC_BRANCH;
                            w_next     = ST_FETCH;
                        end
                        default: w_next = ST_ERR;
                    endcase
                end
                ST_MEM: begin
                    bus.mem_req = 1'b1;
                    bus.iord    = 1'b1;
                    bus.mem_we  = w_is_sw;
                    if (bus.mem_ready) begin
                        w_next = w_is_sw ? ST_FETCH : ST_WB;
                    end else if (w_expire) begin
                        w_next = ST_ERR;
                    end
                end
                ST_WB: begin
                    bus.reg_we = 1'b1;
                    bus.wb_sel = w_is_lw;
                    w_next     = ST_FETCH;
                end
                ST_HALT: bus.halted = 1'b1;
                ST_ERR:  bus.fault  = 1'b1;
                default: w_next = ST_ERR;
            endcase
        end
    end

endmodule
`default_nettype wire
